oam_dma_arbiter: RTL and testbench

//  Owns the system memory bus between the cpu core and a sprite (OAM) DMA engine.
//  A cpu write to DMA_REG with value P stalls the cpu via cpu_rdy.
//  The engine then copies 256 bytes from P*256..P*256+255 to OAM_DATA, as read/write pairs.
//  In IDLE, cpu bus signals pass through combinationally to the memory/PPU bus.

---
 rtl/oam_dma_arbiter.sv | 92 +++++++++
 tb/tb_oam_dma_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter.sv
// Sprite DMA bus arbiter: passes the cpu bus through when idle, and on a write to
// DMA_REG stalls the cpu and copies a 256-byte page to OAM_DATA as read/write pairs.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG  = 16'h4014,
  parameter logic [15:0] OAM_DATA = 16'h2004,
  parameter bit          ALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_we,
  input  logic [7:0]  bus_d_in,
  output logic        dma_active
);

  // state | meaning
  // IDLE  | cpu owns the bus, combinational passthrough
  // HALT  | first stalled cycle after the trigger write
  // ALIGN | extra stall so the first read lands on an even cycle
  // READ  | fetch byte {page,idx} into data
  // WRITE | store data to OAM_DATA, advance idx
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t     state, state_nxt;
  logic [7:0] page, idx, data;
  logic       odd;
  logic       trigger;

  assign trigger = cpu_we && (cpu_addr == DMA_REG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      page  <= 8'h00;
      idx   <= 8'h00;
      data  <= 8'h00;
      odd   <= 1'b0;
    end else begin
      state <= state_nxt;
      odd   <= ~odd;
      case (state)
        IDLE: begin
          if (trigger) begin
            page <= cpu_d_out;
            idx  <= 8'h00;
          end
        end
        READ:  data <= bus_d_in;
        WRITE: idx  <= idx + 8'h01;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    bus_addr   = cpu_addr;
    bus_d_out  = cpu_d_out;
    bus_we     = 1'b0;
    cpu_rdy    = 1'b0;
    dma_active = 1'b1;
    case (state)
      IDLE: begin
        bus_we     = cpu_we;
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        if (trigger) state_nxt = HALT;
      end
      // odd=1 now means the following cycle is even, so READ can start there
      HALT:  state_nxt = (!ALIGN_EN || odd) ? READ : ALIGN;
      ALIGN: state_nxt = READ;
      READ: begin
        bus_addr  = {page, idx};
        bus_d_out = data;
        state_nxt = WRITE;
      end
      WRITE: begin
        bus_addr  = OAM_DATA;
        bus_d_out = data;
        bus_we    = 1'b1;
        state_nxt = (idx == 8'hFF) ? IDLE : READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: two instances (ALIGN_EN=1 and 0) share the cpu
// bus; each sees a memory returning a[7:0]^8'h5A for the address it drives.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_we;

  logic        rdy_a, we_a, act_a, rdy_b, we_b, act_b;
  logic [15:0] addr_a, addr_b;
  logic [7:0]  dout_a, dout_b, din_a, din_b;

  int n_chk = 0;
  int n_err = 0;
  int pc;

  always #5 clk = ~clk;

  assign din_a = addr_a[7:0] ^ 8'h5A;
  assign din_b = addr_b[7:0] ^ 8'h5A;

  // posedges since reset release; its LSB is the expected parity of the current cycle
  always @(posedge clk or negedge rst)
    if (!rst) pc <= 0;
    else      pc <= pc + 1;

  oam_dma_arbiter #(.ALIGN_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out), .cpu_we(cpu_we),
    .cpu_rdy(rdy_a), .bus_addr(addr_a), .bus_d_out(dout_a), .bus_we(we_a),
    .bus_d_in(din_a), .dma_active(act_a));

  oam_dma_arbiter #(.ALIGN_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out), .cpu_we(cpu_we),
    .cpu_rdy(rdy_b), .bus_addr(addr_b), .bus_d_out(dout_b), .bus_we(we_b),
    .bus_d_in(din_b), .dma_active(act_b));

  task automatic cmp(input string tag, input logic [26:0] obs, input logic [26:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pt(input string tag);
    cmp({tag, "_a"}, {rdy_a, act_a, we_a, addr_a, dout_a}, {1'b1, 1'b0, cpu_we, cpu_addr, cpu_d_out});
    cmp({tag, "_b"}, {rdy_b, act_b, we_b, addr_b, dout_b}, {1'b1, 1'b0, cpu_we, cpu_addr, cpu_d_out});
  endtask

  // expected outputs k cycles after the trigger edge; pre = stall cycles before first READ
  task automatic chk(input string tag, input int k, input int pre, input logic [7:0] page,
                     input logic rdy, input logic act, input logic we,
                     input logic [15:0] addr, input logic [7:0] dout);
    int j;
    logic [7:0] w;
    j = k - pre;
    w = 8'(j >> 1);
    if (k < pre)
      cmp({tag, "_halt"}, {8'h00, rdy, act, we, addr}, {8'h00, 1'b0, 1'b1, 1'b0, cpu_addr});
    else if (j < 512 && j % 2 == 0)
      cmp({tag, "_read"}, {8'h00, rdy, act, we, addr}, {8'h00, 1'b0, 1'b1, 1'b0, page, w});
    else if (j < 512)
      cmp({tag, "_write"}, {rdy, act, we, addr, dout}, {1'b0, 1'b1, 1'b1, 16'h2004, w ^ 8'h5A});
    else
      cmp({tag, "_idle"}, {rdy, act, we, addr, dout}, {1'b1, 1'b0, cpu_we, cpu_addr, cpu_d_out});
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    cpu_addr = 16'h1234; cpu_we = 1'b0; cpu_d_out = 8'h00;
    @(negedge clk);
    pt("idle");
  endtask

  task automatic to_parity(input bit want);
    if (pc[0] != want) idle_cycle();
  endtask

  // called at a negedge in IDLE; returns at the negedge of the first cycle both are idle
  task automatic run_dma(input logic [7:0] page, input int abort_k);
    int pre_a, pre_b;
    pre_a = pc[0] ? 2 : 1;
    pre_b = 1;
    cpu_addr = 16'h4014; cpu_we = 1'b1; cpu_d_out = page;
    #1 pt("trig");
    for (int k = 0; k <= pre_a + 512; k++) begin
      @(posedge clk); #1;
      cpu_addr = 16'h1234; cpu_we = 1'b0; cpu_d_out = 8'(k * 7 + 1);
      @(negedge clk);
      chk("dma_a", k, pre_a, page, rdy_a, act_a, we_a, addr_a, dout_a);
      chk("dma_b", k, pre_b, page, rdy_b, act_b, we_b, addr_b, dout_b);
      if (k == abort_k) begin
        rst = 1'b0;
        #1 pt("abort");
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b0; cpu_addr = 16'h0; cpu_d_out = 8'h0; cpu_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      cpu_addr = 16'($urandom); cpu_d_out = 8'($urandom); cpu_we = 1'($urandom);
      if (i == 2) begin cpu_addr = 16'h4014; cpu_we = 1'b1; end
      @(negedge clk);
      pt("reset");
    end
    cpu_addr = 16'h1234; cpu_we = 1'b0;
    rst = 1'b1;
    idle_cycle();

    to_parity(1'b0); run_dma(8'h02, -1);
    to_parity(1'b1); run_dma(8'h02, -1);
    to_parity(1'b0); run_dma(8'hFF, -1);

    @(posedge clk); #1;
    cpu_addr = 16'h4015; cpu_we = 1'b1; cpu_d_out = 8'h02;
    @(negedge clk); pt("w4015");
    @(posedge clk); #1;
    cpu_addr = 16'h4014; cpu_we = 1'b0;
    @(negedge clk); pt("r4014");
    idle_cycle(); idle_cycle();

    to_parity(1'b0); run_dma(8'h03, -1);
    run_dma(8'h04, -1);

    to_parity(1'b0); run_dma(8'h07, 1 + 199);
    @(posedge clk); @(negedge clk); pt("in_rst");
    rst = 1'b1;
    for (int i = 0; i < 8; i++) idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
